ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Two-requester arbiter for port A of the 64 KiB dual-port `memory` block in the DE0 Z80 system, running on `clock_100`. It shares the single read/write port between the Z80 bus interface and a DMA/loader requester (SD-card image loader, debug writer). It serialises their accesses with a req/ack handshake and round-robin fairness. Port B stays dedicated to the video adapter and is untouched.

## Interface
Parameters:
- `RD_LAT`, 2: clock edges from address sampled by memory to `mem_q` valid; legal range 1..3.

Ports:
- `clock`  in  1  system clock (`clock_100`).
- `reset_n`  in  1  asynchronous, active-low reset.
- `cpu_req`  in  1  CPU access request; hold with address/data stable until `cpu_ack`.
- `cpu_we`  in  1  1 = write, 0 = read.
- `cpu_addr`  in  16  byte address.
- `cpu_wdata`  in  8  write data.
- `cpu_rdata`  out  8  read data; registered, valid from `cpu_ack` until the next CPU read completes.
- `cpu_ack`  out  1  one-cycle completion pulse.
- `dma_req`, `dma_we`, `dma_addr`[16], `dma_wdata`[8], `dma_rdata`[8], `dma_ack`: same contract for the DMA requester.
- `mem_addr`  out  16  to memory `address_a`.
- `mem_wdata`  out  8  to memory `data_a`.
- `mem_wren`  out  1  to memory `wren_a`.
- `mem_q`  in  8  from memory `q_a`.
- `grant_dma`  out  1  0 = CPU owns the current or last transaction, 1 = DMA.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, ACK.
- IDLE:
  - If only one req is high, grant it.
  - If both are high, grant the requester that did not win the previous grant.
  - On grant, latch `we`, `addr` and `wdata` from the winner into internal registers, update `grant_dma`, and go to ISSUE.
  - If neither req is high, stay in IDLE.
- ISSUE, one cycle:
  - `mem_addr`/`mem_wdata` are driven from the latched registers. They are held at the latched values through WAIT and ACK.
  - `mem_wren` = latched `we`, and is asserted in this state only.
  - Next state: write → ACK; read → WAIT with counter loaded to `RD_LAT`.
- WAIT:
  - Decrement the counter each cycle.
  - In the last WAIT cycle (counter = 1), capture `mem_q` into the granted requester's `rdata` register and go to ACK.
  - WAIT lasts exactly `RD_LAT` cycles.
- ACK, one cycle:
  - Assert the granted requester's `ack`.
  - Go to IDLE.
- The non-granted requester's `rdata` is never modified.
- Handshake rule: a requester must deassert `req` in the cycle after `ack`. If `req` is still high when IDLE samples it, that is a new transaction.
- Requester signals are only sampled in IDLE. Changes to a requester's signals while it is granted are ignored.
- Round-robin pointer (`grant_dma`) resets to 1, so the first tie goes to the CPU.

## Timing
- Reset (asynchronous, immediate):
  - State = IDLE.
  - `mem_wren`=0, `mem_addr`=0, `mem_wdata`=0.
  - `cpu_ack`=`dma_ack`=0, `cpu_rdata`=`dma_rdata`=0.
  - `busy`=0, `grant_dma`=1.
- Reset mid-transaction aborts it: no ack is issued, and `mem_wren` drops without waiting for a clock edge.
- Cycle numbering: req is sampled high at the end of cycle 0.
- Write:
  - `mem_wren`=1 in cycle 1.
  - `ack` in cycle 2.
  - Total latency 2 cycles.
- Read:
  - Address is presented in cycle 1.
  - WAIT occupies cycles 2..1+`RD_LAT`; `mem_q` is captured at the end of cycle 1+`RD_LAT`.
  - `ack` and valid `rdata` appear in cycle 2+`RD_LAT` (cycle 4 for the default).
- Back-to-back:
  - The earliest next grant is sampled in the IDLE cycle after ACK.
  - Minimum spacing between successive ISSUE cycles: write 3 cycles, read `RD_LAT`+3 cycles.
- Z80 at 3.5 MHz versus a 100 MHz arbiter: worst-case CPU wait (one DMA read ahead) is 2·(`RD_LAT`+3) = 10 cycles, i.e. 100 ns. This is well inside a Z80 T-state.
- `busy` is registered: high from cycle 1 through the ACK cycle inclusive.

## Test plan
- CPU write: `cpu_req`=1, `cpu_we`=1, addr 0x4000, data 0xA5 → `mem_wren`=1 with `mem_addr`=0x4000 and `mem_wdata`=0xA5 in cycle 1 only; `cpu_ack` in cycle 2; `dma_ack` never asserted.
- CPU read, `RD_LAT`=2: preload 0x3C at 0x1234, CPU read 0x1234 → `mem_wren` stays 0; `cpu_ack` in cycle 4 with `cpu_rdata`=0x3C; `dma_rdata` unchanged.
- Tie after reset: both req high in the same cycle (CPU write 0x0001←0x11, DMA write 0x0002←0x22) → CPU is served first and `cpu_ack` fires first; DMA is granted in the following IDLE; memory ends with 0x11 and 0x22 in those locations.
- Fairness: CPU and DMA hold req continuously for 6 reads each → grants strictly alternate CPU, DMA, CPU, …; neither requester gets two consecutive grants.
- Reset mid-read: assert `reset_n`=0 during WAIT → `busy`, `mem_wren` and both acks are 0 immediately; no ack after release; the next request completes with normal latency.
- `RD_LAT`=1 and `RD_LAT`=3 builds: read ack arrives in cycle 3 and cycle 5 respectively, with correct data.

Source files
------------

// File: rtl/ram_arbiter.sv
// Round-robin req/ack arbiter sharing the single read/write port A of the video/system
// dual-port RAM between the Z80 bus interface and a DMA/loader requester.
module ram_arbiter #(
  parameter int unsigned RD_LAT = 2,
  localparam int unsigned AW = 16,
  localparam int unsigned DW = 8
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic [DW-1:0] dma_rdata,
  output logic          dma_ack,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_wren,
  input  logic [DW-1:0] mem_q,
  output logic          grant_dma,
  output logic          busy
);

  localparam int unsigned CW = 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_ACK   = 2'd3
  } state_t;

  state_t        r_state;
  logic          r_we;
  logic [CW-1:0] r_cnt;

  logic          w_any;
  logic          w_pick_dma;
  logic          w_we;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_wdata;

  // On a tie the requester that did not win last time (grant_dma holds the last winner) goes first.
  assign w_any      = cpu_req | dma_req;
  assign w_pick_dma = dma_req & (~cpu_req | ~grant_dma);
  assign w_we       = w_pick_dma ? dma_we    : cpu_we;
  assign w_addr     = w_pick_dma ? dma_addr  : cpu_addr;
  assign w_wdata    = w_pick_dma ? dma_wdata : cpu_wdata;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_we      <= 1'b0;
      r_cnt     <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wren  <= 1'b0;
      cpu_rdata <= '0;
      dma_rdata <= '0;
      cpu_ack   <= 1'b0;
      dma_ack   <= 1'b0;
      grant_dma <= 1'b1;
      busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            grant_dma <= w_pick_dma;
            r_we      <= w_we;
            mem_addr  <= w_addr;
            mem_wdata <= w_wdata;
            mem_wren  <= w_we;
            busy      <= 1'b1;
            r_state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          mem_wren <= 1'b0;
          if (r_we) begin
            cpu_ack <= ~grant_dma;
            dma_ack <= grant_dma;
            r_state <= S_ACK;
          end else begin
            r_cnt   <= CW'(RD_LAT);
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - CW'(1);
          // Last wait cycle: read data is valid on mem_q, capture it for the owner only.
          if (r_cnt == CW'(1)) begin
            if (grant_dma) begin
              dma_rdata <= mem_q;
            end else begin
              cpu_rdata <= mem_q;
            end
            cpu_ack <= ~grant_dma;
            dma_ack <= grant_dma;
            r_state <= S_ACK;
          end
        end
        S_ACK: begin
          cpu_ack <= 1'b0;
          dma_ack <= 1'b0;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: three builds (RD_LAT 1..3), each with its own memory,
// transaction-timeline reference model, directed scenarios and randomized requesters.
module tb_ram_arbiter;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  function automatic void check(input int lat, input string name,
                                input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL lat%0d %s: got 0x%0h expected 0x%0h at %0t", lat, name, act, exp, $time);
    end
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int LAT    = g + 1;
    localparam int EXP_RD = (g == 0) ? 3 : (g == 1) ? 4 : 5;

    logic        reset_n = 1'b0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0, dma_req = 1'b0, dma_we = 1'b0;
    logic [15:0] cpu_addr = '0, dma_addr = '0, mem_addr;
    logic [7:0]  cpu_wdata = '0, dma_wdata = '0, cpu_rdata, dma_rdata, mem_wdata, mem_q;
    logic        cpu_ack, dma_ack, mem_wren, grant_dma, busy;
    bit          done_i = 1'b0;

    ram_arbiter #(.RD_LAT(LAT)) u_dut (
      .clock(clock), .reset_n(reset_n),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_rdata(dma_rdata), .dma_ack(dma_ack),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren), .mem_q(mem_q),
      .grant_dma(grant_dma), .busy(busy)
    );

    // Synchronous RAM: address sampled on an edge, q valid LAT edges later.
    logic [7:0] mem [65536];
    logic [7:0] pipe [3];
    always @(posedge clock) begin
      if (mem_wren) mem[mem_addr] <= mem_wdata;
      pipe[0] <= mem[mem_addr];
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
    end
    assign mem_q = pipe[LAT-1];

    // Reference model: a granted transaction occupies cycles 1..L after the grant (L = 2 for a
    // write, LAT+2 for a read); k is the position in that timeline, 0 when idle.
    int          k = 0, L = 0;
    bit          m_dma = 1'b0, m_we = 1'b0, m_last_dma = 1'b1;
    logic [15:0] m_addr = '0;
    logic [7:0]  m_wd = '0, m_rdv = '0, m_cpu_rd = '0, m_dma_rd = '0;
    logic [7:0]  shadow [65536];

    always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        k = 0; m_last_dma = 1'b1; m_cpu_rd = '0; m_dma_rd = '0;
        m_addr = '0; m_wd = '0; m_we = 1'b0;
      end else if (k == 0) begin
        if (cpu_req || dma_req) begin
          m_dma      = (cpu_req && dma_req) ? !m_last_dma : dma_req;
          m_last_dma = m_dma;
          m_we       = m_dma ? dma_we    : cpu_we;
          m_addr     = m_dma ? dma_addr  : cpu_addr;
          m_wd       = m_dma ? dma_wdata : cpu_wdata;
          L          = m_we ? 2 : LAT + 2;
          k          = 1;
          if (m_we) shadow[m_addr] = m_wd;
          else      m_rdv = shadow[m_addr];
        end
      end else if (k == L) begin
        k = 0;
      end else begin
        k++;
        if (k == L && !m_we) begin
          if (m_dma) m_dma_rd = m_rdv;
          else       m_cpu_rd = m_rdv;
        end
      end
    end

    always @(negedge clock) begin
      if (reset_n) begin
        check(LAT, "outputs",
              32'({busy, mem_wren, cpu_ack, dma_ack, grant_dma, cpu_rdata, dma_rdata}),
              32'({k >= 1, k == 1 && m_we, k > 0 && k == L && !m_dma, k > 0 && k == L && m_dma,
                   m_last_dma, m_cpu_rd, m_dma_rd}));
        if (k >= 1) check(LAT, "mem_bus", 32'({mem_addr, mem_wdata}), 32'({m_addr, m_wd}));
      end
    end

    task automatic drive(input bit dma, input bit we, input logic [15:0] a, input logic [7:0] d);
      if (dma) begin dma_req = 1'b1; dma_we = we; dma_addr = a; dma_wdata = d; end
      else     begin cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d; end
    endtask

    // One transaction; cycle 0 is the cycle in which req is first sampled.
    task automatic txn(input bit dma, input bit we, input logic [15:0] a, input logic [7:0] d,
                       output int ack_cyc, output int wren_mask,
                       output logic [15:0] a1, output logic [7:0] d1);
      @(negedge clock);
      drive(dma, we, a, d);
      ack_cyc = -1; wren_mask = 0; a1 = '0; d1 = '0;
      for (int c = 1; c <= 12 && ack_cyc < 0; c++) begin
        @(negedge clock);
        if (mem_wren) wren_mask |= (1 << c);
        if (c == 1) begin a1 = mem_addr; d1 = mem_wdata; end
        if (dma ? dma_ack : cpu_ack) ack_cyc = c;
      end
      if (dma) dma_req = 1'b0; else cpu_req = 1'b0;
    endtask

    task automatic rnd_drv(input bit dma, input int n);
      for (int i = 0; i < n; i++) begin
        int w;
        repeat ($urandom_range(0, 3)) @(negedge clock);
        drive(dma, 1'($urandom), 16'h0A00 | 16'($urandom_range(0, 15)), 8'($urandom));
        w = 0;
        do begin @(negedge clock); w++; end while (!(dma ? dma_ack : cpu_ack) && w < 60);
        if (w >= 60) check(LAT, dma ? "dma_ack_timeout" : "cpu_ack_timeout", 32'(w), 32'(0));
        if (dma) dma_req = 1'b0; else cpu_req = 1'b0;
      end
    endtask

    int          ac, wm, ca, da, cnt_c, cnt_d, prev, alt_err, seen;
    logic [15:0] a1;
    logic [7:0]  d1;

    initial begin
      repeat (2) @(negedge clock);
      check(LAT, "rst_ctrl", 32'({busy, mem_wren, cpu_ack, dma_ack, grant_dma}), 32'h01);
      check(LAT, "rst_data", 32'({cpu_rdata, dma_rdata, mem_wdata}), 32'h0);
      check(LAT, "rst_addr", 32'(mem_addr), 32'h0);
      reset_n = 1'b1;

      // CPU write
      txn(1'b0, 1'b1, 16'h4000, 8'hA5, ac, wm, a1, d1);
      check(LAT, "wr_ack_cycle", 32'(ac), 32'd2);
      check(LAT, "wr_wren_cycles", 32'(wm), 32'h2);
      check(LAT, "wr_bus_c1", 32'({a1, d1}), 32'h4000A5);

      // Preload by DMA, then CPU read
      txn(1'b1, 1'b1, 16'h1234, 8'h3C, ac, wm, a1, d1);
      txn(1'b0, 1'b0, 16'h1234, 8'h00, ac, wm, a1, d1);
      check(LAT, "rd_ack_cycle", 32'(ac), 32'(EXP_RD));
      check(LAT, "rd_wren_cycles", 32'(wm), 32'h0);
      check(LAT, "rd_data", 32'(cpu_rdata), 32'h3C);
      check(LAT, "rd_dma_rdata_kept", 32'(dma_rdata), 32'h0);

      // Tie straight after reset
      @(negedge clock); reset_n = 1'b0;
      @(negedge clock); reset_n = 1'b1;
      @(negedge clock);
      drive(1'b0, 1'b1, 16'h0001, 8'h11);
      drive(1'b1, 1'b1, 16'h0002, 8'h22);
      ca = -1; da = -1;
      for (int c = 1; c <= 20 && (ca < 0 || da < 0); c++) begin
        @(negedge clock);
        if (cpu_ack) begin ca = c; cpu_req = 1'b0; end
        if (dma_ack) begin da = c; dma_req = 1'b0; end
      end
      check(LAT, "tie_cpu_ack_cycle", 32'(ca), 32'd2);
      check(LAT, "tie_dma_ack_cycle", 32'(da), 32'd5);
      txn(1'b0, 1'b0, 16'h0001, 8'h00, ac, wm, a1, d1);
      check(LAT, "tie_mem_0001", 32'(cpu_rdata), 32'h11);
      txn(1'b0, 1'b0, 16'h0002, 8'h00, ac, wm, a1, d1);
      check(LAT, "tie_mem_0002", 32'(cpu_rdata), 32'h22);

      // Fairness: both hold req for 6 reads each
      cnt_c = 0; cnt_d = 0; prev = -1; alt_err = 0;
      @(negedge clock);
      drive(1'b0, 1'b0, 16'h0001, 8'h00);
      drive(1'b1, 1'b0, 16'h0002, 8'h00);
      for (int c = 0; c < 200 && (cnt_c < 6 || cnt_d < 6); c++) begin
        @(negedge clock);
        if (cpu_ack) begin
          if (prev == 0) alt_err++;
          prev = 0; cnt_c++;
          if (cnt_c == 6) cpu_req = 1'b0;
        end
        if (dma_ack) begin
          if (prev == 1) alt_err++;
          prev = 1; cnt_d++;
          if (cnt_d == 6) dma_req = 1'b0;
        end
      end
      cpu_req = 1'b0; dma_req = 1'b0;
      check(LAT, "fair_counts", 32'(cnt_c * 16 + cnt_d), 32'h66);
      check(LAT, "fair_alternation", 32'(alt_err), 32'd0);

      // Reset in the middle of a read
      @(negedge clock);
      drive(1'b0, 1'b0, 16'h1234, 8'h00);
      repeat (2) @(negedge clock);
      #1 reset_n = 1'b0; cpu_req = 1'b0;
      #1 check(LAT, "midrst_outputs", 32'({busy, mem_wren, cpu_ack, dma_ack}), 32'h0);
      repeat (2) @(negedge clock);
      #1 reset_n = 1'b1;
      seen = 0;
      repeat (6) begin @(negedge clock); if (cpu_ack || dma_ack) seen++; end
      check(LAT, "midrst_no_ack", 32'(seen), 32'd0);
      txn(1'b0, 1'b1, 16'h2000, 8'h5A, ac, wm, a1, d1);
      check(LAT, "midrst_wr_ack_cycle", 32'(ac), 32'd2);
      txn(1'b0, 1'b0, 16'h1234, 8'h00, ac, wm, a1, d1);
      check(LAT, "midrst_rd_ack_cycle", 32'(ac), 32'(EXP_RD));
      check(LAT, "midrst_rd_data", 32'(cpu_rdata), 32'h3C);

      // Fill the random window, then random traffic from both requesters
      for (int i = 0; i < 16; i++)
        txn(1'b0, 1'b1, 16'h0A00 | 16'(i), 8'($urandom), ac, wm, a1, d1);
      fork
        rnd_drv(1'b0, 120);
        rnd_drv(1'b1, 120);
      join
      repeat (10) @(negedge clock);
      done_i = 1'b1;
    end
  end

  initial begin
    int ndone;
    ndone = 0;
    for (int t = 0; t < 60000 && ndone < 3; t++) begin
      @(posedge clock);
      ndone = int'(g_inst[0].done_i) + int'(g_inst[1].done_i) + int'(g_inst[2].done_i);
    end
    check(0, "all_builds_done", 32'(ndone), 32'd3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
